// File: rtl/spi_slave_sys_responder.sv
// System-clock responder for the SPI slave command path: synchronizes SPI-domain toggles
// and runs one-outstanding, auto-incrementing word transfers on a req/gnt/rvalid bus.
module spi_slave_sys_responder #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 32
) (
   input  logic                      sys_clk,
   input  logic                      rstn,
   input  logic                      cs_sync,
   input  logic [AXI_ADDR_WIDTH-1:0] address_sync,
   input  logic                      address_valid_sync,
   input  logic                      rd_wr_sync,
   input  logic [AXI_DATA_WIDTH-1:0] wr_data,
   input  logic                      wr_toggle,
   input  logic                      rd_ack_toggle,
   output logic                      bus_req,
   output logic                      bus_we,
   output logic [AXI_ADDR_WIDTH-1:0] bus_addr,
   output logic [AXI_DATA_WIDTH-1:0] bus_wdata,
   input  logic                      bus_gnt,
   input  logic                      bus_rvalid,
   input  logic [AXI_DATA_WIDTH-1:0] bus_rdata,
   output logic [AXI_DATA_WIDTH-1:0] rd_data,
   output logic                      rd_data_valid,
   output logic                      busy,
   output logic                      overrun
);

   typedef enum logic [2:0] {
      IDLE, RD_REQ, RD_WAIT, RD_HOLD, WR_IDLE, WR_REQ, WR_WAIT, DRAIN
   } state_t;

   state_t                    r_state;
   logic [2:0]                r_wr_sync;
   logic [2:0]                r_ack_sync;
   logic [AXI_ADDR_WIDTH-1:0] r_base;
   logic [AXI_ADDR_WIDTH-1:0] r_count;
   logic [AXI_ADDR_WIDTH-1:0] r_addr;
   logic [AXI_DATA_WIDTH-1:0] r_wdata;
   logic [AXI_DATA_WIDTH-1:0] r_rd_data;
   logic                      r_req;
   logic                      r_we;
   logic                      r_rd_data_valid;
   logic                      r_busy;
   logic                      r_overrun;

   logic                      w_wr_ev;
   logic                      w_ack_ev;
   logic                      w_cmd;
   logic                      w_accept;
   logic [AXI_ADDR_WIDTH-1:0] w_next_count;
   logic [AXI_ADDR_WIDTH-1:0] w_next_addr;

   // Three-stage synchronizers; the event fires once per toggle edge.
   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_sync  <= '0;
         r_ack_sync <= '0;
      end else begin
         r_wr_sync  <= {r_wr_sync[1:0], wr_toggle};
         r_ack_sync <= {r_ack_sync[1:0], rd_ack_toggle};
      end
   end

   assign w_wr_ev      = r_wr_sync[2] ^ r_wr_sync[1];
   assign w_ack_ev     = r_ack_sync[2] ^ r_ack_sync[1];
   assign w_cmd        = address_valid_sync & ~cs_sync;
   assign w_accept     = w_cmd & ((r_state == IDLE) || (r_state == RD_HOLD) || (r_state == WR_IDLE));
   assign w_next_count = r_count + AXI_ADDR_WIDTH'(1);
   assign w_next_addr  = r_base + (w_next_count << 2);

   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         r_state         <= IDLE;
         r_base          <= '0;
         r_count         <= '0;
         r_addr          <= '0;
         r_wdata         <= '0;
         r_rd_data       <= '0;
         r_req           <= 1'b0;
         r_we            <= 1'b0;
         r_rd_data_valid <= 1'b0;
         r_busy          <= 1'b0;
         r_overrun       <= 1'b0;
      end else begin
         // NOTE: busy defaults low each cycle; states with a transfer in flight re-assert it,
         // which also holds it high for the cycle after rvalid.
         r_busy <= 1'b0;
         if (w_accept) begin
            r_base          <= address_sync;
            r_count         <= '0;
            r_addr          <= address_sync;
            r_overrun       <= 1'b0;
            r_rd_data_valid <= 1'b0;
            if (rd_wr_sync) begin
               r_state <= RD_REQ;
               r_req   <= 1'b1;
               r_we    <= 1'b0;
               r_busy  <= 1'b1;
            end else begin
               r_state <= WR_IDLE;
            end
         end else begin
            if (w_cmd) r_overrun <= 1'b1;
            case (r_state)
               IDLE: ;
               RD_HOLD: begin
                  if (cs_sync) begin
                     r_state <= IDLE;
                  end else if (w_ack_ev) begin
                     r_rd_data_valid <= 1'b0;
                     r_state         <= RD_REQ;
                     r_req           <= 1'b1;
                     r_we            <= 1'b0;
                     r_busy          <= 1'b1;
                  end
               end
               WR_IDLE: begin
                  if (cs_sync) begin
                     r_state <= IDLE;
                  end else if (w_wr_ev) begin
                     r_wdata <= wr_data;
                     r_state <= WR_REQ;
                     r_req   <= 1'b1;
                     r_we    <= 1'b1;
                     r_busy  <= 1'b1;
                  end
               end
               RD_REQ, WR_REQ: begin
                  r_busy <= 1'b1;
                  if (r_state == WR_REQ && w_wr_ev) r_overrun <= 1'b1;
                  if (bus_gnt) r_req <= 1'b0;
                  // An abort while ungranted still holds req; DRAIN finishes the handshake.
                  if (cs_sync)      r_state <= DRAIN;
                  else if (bus_gnt) r_state <= (r_state == RD_REQ) ? RD_WAIT : WR_WAIT;
               end
               RD_WAIT: begin
                  r_busy <= 1'b1;
                  if (bus_rvalid) begin
                     r_count <= w_next_count;
                     r_addr  <= w_next_addr;
                     if (cs_sync) begin
                        r_state <= IDLE;
                     end else begin
                        r_rd_data       <= bus_rdata;
                        r_rd_data_valid <= 1'b1;
                        r_state         <= RD_HOLD;
                     end
                  end else if (cs_sync) begin
                     r_state <= DRAIN;
                  end
               end
               WR_WAIT: begin
                  r_busy <= 1'b1;
                  if (w_wr_ev) r_overrun <= 1'b1;
                  if (bus_rvalid) begin
                     r_count <= w_next_count;
                     r_addr  <= w_next_addr;
                     r_state <= cs_sync ? IDLE : WR_IDLE;
                  end else if (cs_sync) begin
                     r_state <= DRAIN;
                  end
               end
               DRAIN: begin
                  r_busy <= 1'b1;
                  if (r_req) begin
                     if (bus_gnt) r_req <= 1'b0;
                  end else if (bus_rvalid) begin
                     r_count <= w_next_count;
                     r_addr  <= w_next_addr;
                     r_state <= IDLE;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
         // NOTE: last non-blocking assignment wins, so chip-select release overrides any set above.
         if (cs_sync) r_rd_data_valid <= 1'b0;
      end
   end

   assign bus_req       = r_req;
   assign bus_we        = r_we;
   assign bus_addr      = r_addr;
   assign bus_wdata     = r_wdata;
   assign rd_data       = r_rd_data;
   assign rd_data_valid = r_rd_data_valid;
   assign busy          = r_busy;
   assign overrun       = r_overrun;

endmodule

// File: tb/tb_spi_slave_sys_responder.sv
// Self-checking bench for spi_slave_sys_responder: vector table of bursts, a bus responder
// with a transaction scoreboard, and hand-written abort/overrun/reset sequences.
module tb_spi_slave_sys_responder;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } txn_t;

   typedef struct {
      logic        rd;
      logic [31:0] base;
      int          nwords;
      int          gnt_dly;
      logic [31:0] data0;
      logic [31:0] dstep;
      logic [31:0] exp_end;
   } vec_t;

   logic        sys_clk = 1'b0;
   logic        rstn;
   logic        cs_sync;
   logic [31:0] address_sync;
   logic        address_valid_sync;
   logic        rd_wr_sync;
   logic [31:0] wr_data;
   logic        wr_toggle;
   logic        rd_ack_toggle;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_gnt;
   logic        bus_rvalid;
   logic [31:0] bus_rdata;
   logic [31:0] rd_data;
   logic        rd_data_valid;
   logic        busy;
   logic        overrun;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_grants = 0;
   int          gnt_delay = 0;
   int          rv_delay  = 1;
   bit          expect_rd_out = 1'b1;

   txn_t        exp_txn[$];
   logic [31:0] rd_words[$];
   logic [31:0] exp_rd[$];

   vec_t        vecs[5];
   vec_t        cur;
   txn_t        tx;
   int          g0;

   always #5 sys_clk = ~sys_clk;

   spi_slave_sys_responder #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)) dut (
      .sys_clk            (sys_clk),
      .rstn               (rstn),
      .cs_sync            (cs_sync),
      .address_sync       (address_sync),
      .address_valid_sync (address_valid_sync),
      .rd_wr_sync         (rd_wr_sync),
      .wr_data            (wr_data),
      .wr_toggle          (wr_toggle),
      .rd_ack_toggle      (rd_ack_toggle),
      .bus_req            (bus_req),
      .bus_we             (bus_we),
      .bus_addr           (bus_addr),
      .bus_wdata          (bus_wdata),
      .bus_gnt            (bus_gnt),
      .bus_rvalid         (bus_rvalid),
      .bus_rdata          (bus_rdata),
      .rd_data            (rd_data),
      .rd_data_valid      (rd_data_valid),
      .busy               (busy),
      .overrun            (overrun)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #2;
   endtask

   // Bus responder and transaction scoreboard, acting on the falling edge.
   int          rsp_phase = 0;
   int          rsp_cnt   = 0;
   logic        rsp_we;
   logic        hold_we;
   logic [31:0] hold_addr;
   logic [31:0] hold_wdata;
   txn_t        got;

   always @(negedge sys_clk) begin
      if (!rstn) begin
         bus_gnt    = 1'b0;
         bus_rvalid = 1'b0;
         bus_rdata  = '0;
         rsp_phase  = 0;
         rsp_cnt    = 0;
      end else begin
         bus_gnt    = 1'b0;
         bus_rvalid = 1'b0;
         if (rsp_phase == 0) begin
            if (rsp_cnt > 0) check("stall_req_held", bus_req, 1'b1);
            if (bus_req) begin
               if (rsp_cnt == 0) begin
                  hold_we    = bus_we;
                  hold_addr  = bus_addr;
                  hold_wdata = bus_wdata;
               end else begin
                  check("stall_we", bus_we, hold_we);
                  check("stall_addr", bus_addr, hold_addr);
                  check("stall_wdata", bus_wdata, hold_wdata);
               end
               if (rsp_cnt >= gnt_delay) begin
                  bus_gnt = 1'b1;
                  n_grants++;
                  if (exp_txn.size() == 0) begin
                     n_checks++;
                     n_fail++;
                     $display("FAIL unexpected_txn: got addr=%h we=%0d, expected no transfer", bus_addr, bus_we);
                  end else begin
                     got = exp_txn.pop_front();
                     check("txn_we", bus_we, got.we);
                     check("txn_addr", bus_addr, got.addr);
                     if (got.we) check("txn_wdata", bus_wdata, got.wdata);
                  end
                  rsp_we    = bus_we;
                  rsp_phase = 1;
                  rsp_cnt   = 0;
               end else begin
                  rsp_cnt++;
               end
            end else begin
               rsp_cnt = 0;
            end
         end else begin
            rsp_cnt++;
            if (rsp_cnt >= rv_delay) begin
               bus_rvalid = 1'b1;
               if (!rsp_we) begin
                  if (rd_words.size() > 0) bus_rdata = rd_words.pop_front();
                  else                     bus_rdata = 32'h0BAD_F00D;
                  if (expect_rd_out) exp_rd.push_back(bus_rdata);
               end
               rsp_phase = 0;
               rsp_cnt   = 0;
            end
         end
      end
   end

   // Read-data monitor: each new rd_data_valid must carry the next returned word.
   logic        prev_rdv = 1'b0;
   logic [31:0] exp_word;
   always @(negedge sys_clk) begin
      if (rstn && rd_data_valid && !prev_rdv) begin
         if (exp_rd.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rd_data: got %h, expected no word", rd_data);
         end else begin
            exp_word = exp_rd.pop_front();
            check("rd_data", rd_data, exp_word);
         end
      end
      prev_rdv = rd_data_valid;
   end

   task automatic send_cmd(input logic rd, input logic [31:0] a);
      address_sync       = a;
      rd_wr_sync         = rd;
      address_valid_sync = 1'b1;
      tick();
      address_valid_sync = 1'b0;
   endtask

   task automatic wait_rdv(input logic level, input string nm);
      int k = 0;
      while (rd_data_valid !== level && k < 100) begin
         tick();
         k++;
      end
      check(nm, rd_data_valid, level);
   endtask

   task automatic wait_grants(input int target, input string nm);
      int k = 0;
      while (n_grants < target && k < 100) begin
         tick();
         k++;
      end
      check(nm, n_grants, target);
   endtask

   task automatic wait_idle(input string nm);
      int k = 0;
      while (busy !== 1'b0 && k < 100) begin
         tick();
         k++;
      end
      check(nm, busy, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{rd:1'b1, base:32'h0000_1000, nwords:2, gnt_dly:0, data0:32'hA5A5_0001, dstep:32'h1,     exp_end:32'h0000_1008};
      vecs[1] = '{rd:1'b0, base:32'h0000_2000, nwords:3, gnt_dly:0, data0:32'h0000_0011, dstep:32'h11,    exp_end:32'h0000_200C};
      vecs[2] = '{rd:1'b1, base:32'hFFFF_FFFC, nwords:2, gnt_dly:0, data0:32'hC0DE_0000, dstep:32'h10,    exp_end:32'h0000_0004};
      vecs[3] = '{rd:1'b1, base:32'h0000_3000, nwords:1, gnt_dly:5, data0:32'h1234_5678, dstep:32'h0,     exp_end:32'h0000_3004};
      vecs[4] = '{rd:1'b0, base:32'h0000_4000, nwords:2, gnt_dly:5, data0:32'hCAFE_0001, dstep:32'h100,   exp_end:32'h0000_4008};

      rstn               = 1'b0;
      cs_sync            = 1'b0;
      address_sync       = '0;
      address_valid_sync = 1'b0;
      rd_wr_sync         = 1'b0;
      wr_data            = '0;
      wr_toggle          = 1'b0;
      rd_ack_toggle      = 1'b0;
      repeat (3) tick();
      check("rst_bus_req", bus_req, 1'b0);
      check("rst_bus_we", bus_we, 1'b0);
      check("rst_bus_addr", bus_addr, 32'h0);
      check("rst_bus_wdata", bus_wdata, 32'h0);
      check("rst_rd_data", rd_data, 32'h0);
      check("rst_rd_data_valid", rd_data_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_overrun", overrun, 1'b0);
      rstn = 1'b1;
      repeat (2) tick();

      for (int v = 0; v < 5; v++) begin
         cur           = vecs[v];
         gnt_delay     = cur.gnt_dly;
         rv_delay      = 1;
         expect_rd_out = 1'b1;
         g0            = n_grants;
         for (int i = 0; i < cur.nwords; i++) begin
            tx.we    = ~cur.rd;
            tx.addr  = cur.base + 32'(4 * i);
            tx.wdata = cur.data0 + cur.dstep * 32'(i);
            exp_txn.push_back(tx);
            if (cur.rd) rd_words.push_back(cur.data0 + cur.dstep * 32'(i));
         end
         send_cmd(cur.rd, cur.base);
         check("cmd_req_n1", bus_req, cur.rd);
         check("cmd_addr_n1", bus_addr, cur.base);
         for (int i = 0; i < cur.nwords; i++) begin
            if (cur.rd) begin
               wait_rdv(1'b1, "rd_valid_rise");
               check("busy_after_rvalid", busy, 1'b1);
               if (i < cur.nwords - 1) begin
                  rd_ack_toggle = ~rd_ack_toggle;
                  wait_rdv(1'b0, "rd_valid_ack_clear");
               end
            end else begin
               wr_data   = cur.data0 + cur.dstep * 32'(i);
               wr_toggle = ~wr_toggle;
               wait_grants(g0 + i + 1, "wr_grant");
               wait_idle("wr_done");
               check("wr_overrun", overrun, 1'b0);
            end
         end
         if (cur.rd) begin
            tick();
            check("busy_drop", busy, 1'b0);
            check("rd_hold_valid", rd_data_valid, 1'b1);
         end
         cs_sync = 1'b1;
         tick();
         check("cs_clears_rdv", rd_data_valid, 1'b0);
         check("end_busy", busy, 1'b0);
         check("end_addr", bus_addr, cur.exp_end);
         check("end_overrun", overrun, 1'b0);
         check("transfer_count", n_grants - g0, cur.nwords);
         cs_sync = 1'b0;
         tick();
      end

      // Chip-select abort while the read request is still ungranted.
      gnt_delay     = 6;
      expect_rd_out = 1'b0;
      g0            = n_grants;
      tx.we    = 1'b0;
      tx.addr  = 32'h0000_5000;
      tx.wdata = '0;
      exp_txn.push_back(tx);
      send_cmd(1'b1, 32'h0000_5000);
      check("abort_req_n1", bus_req, 1'b1);
      cs_sync = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("abort_req_held", bus_req, 1'b1);
      end
      wait_grants(g0 + 1, "abort_grant");
      wait_idle("abort_drain_done");
      check("abort_req_low", bus_req, 1'b0);
      check("abort_rdv", rd_data_valid, 1'b0);
      check("abort_addr", bus_addr, 32'h0000_5004);
      cs_sync       = 1'b0;
      gnt_delay     = 0;
      expect_rd_out = 1'b1;
      tick();

      // Second write toggle during WR_WAIT is dropped and flags overrun.
      rv_delay = 6;
      g0       = n_grants;
      tx.we    = 1'b1;
      tx.addr  = 32'h0000_6000;
      tx.wdata = 32'h0000_0077;
      exp_txn.push_back(tx);
      send_cmd(1'b0, 32'h0000_6000);
      check("ovr_cmd_no_req", bus_req, 1'b0);
      wr_data   = 32'h0000_0077;
      wr_toggle = ~wr_toggle;
      wait_grants(g0 + 1, "ovr_first_grant");
      wr_data   = 32'h0000_0088;
      wr_toggle = ~wr_toggle;
      wait_idle("ovr_first_done");
      check("ovr_set", overrun, 1'b1);
      repeat (6) tick();
      check("ovr_word_dropped", n_grants - g0, 1);
      check("ovr_sticky", overrun, 1'b1);
      send_cmd(1'b0, 32'h0000_7000);
      check("ovr_cleared", overrun, 1'b0);
      check("ovr_new_base", bus_addr, 32'h0000_7000);
      cs_sync = 1'b1;
      tick();
      cs_sync  = 1'b0;
      rv_delay = 1;
      tick();

      // Reset asserted while a request is pending.
      gnt_delay = 20;
      tx.we    = 1'b0;
      tx.addr  = 32'h0000_8000;
      tx.wdata = '0;
      exp_txn.push_back(tx);
      send_cmd(1'b1, 32'h0000_8000);
      check("rstmid_req", bus_req, 1'b1);
      tick();
      rstn = 1'b0;
      #1;
      check("rstmid_req_low", bus_req, 1'b0);
      check("rstmid_busy", busy, 1'b0);
      check("rstmid_addr", bus_addr, 32'h0);
      exp_txn.delete();
      tick();
      rstn      = 1'b1;
      gnt_delay = 0;
      repeat (3) tick();
      check("rstmid_idle_req", bus_req, 1'b0);

      check("txn_queue_empty", exp_txn.size(), 0);
      check("rd_queue_empty", exp_rd.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
